mips_bus_master: RTL and testbench

- Avalon-MM master sequencer between the multicycle MIPS core and the memory bus.
- Accepts one byte, half or word load/store from the core at a time and runs it as a single Avalon transfer.
- Lane logic: word-aligns the address, generates byteenable, replicates write data across lanes, and extracts and sign- or zero-extends read data.
- Flags misalignment and a waitrequest timeout, so the core FSM no longer handles bus lanes or stall timing itself.

---
 rtl/mips_bus_pkg.sv | 58 +++++
 rtl/mips_load_extract.sv | 26 ++
 rtl/mips_bus_master.sv | 144 ++++++++++++++
 tb/tb_mips_bus_master.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and lane helpers for the MIPS-to-Avalon bus master.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_ALIGN   = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Lane enables for an access of the given size at byte offset off.
    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Right-justified store data copied onto every lane it could land on,
    // so the slave only has to honour byteenable.
    function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{data[7:0]}};
            SZ_HALF: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    // A half must sit on an even address, a word on a multiple of four;
    // size code 3 is reserved and always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mips_load_extract.sv
// Pulls the addressed byte/half out of a 32-bit bus word and sign- or
// zero-extends it to a full register value.
module mips_load_extract
    import mips_bus_pkg::*;
(
    input  logic [31:0] readdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then mask and extend per size.
    always_comb begin
        shifted = readdata_i >> {off_i, 3'b000};
        rdata_o = shifted;
        case (size_i)
            SZ_BYTE: rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            SZ_HALF: rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/mips_bus_master.sv
// Avalon-MM master sequencer: runs one core load/store at a time as a single
// bus transfer, handling lanes, extension, alignment errors and stall timeout.
module mips_bus_master
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic              write,
    output logic              read,
    input  logic              waitrequest,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic [31:0]       readdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 2);

    state_e            state_q;
    logic [ADDR_W-1:0] address_q;
    logic              read_q;
    logic              write_q;
    logic [31:0]       writedata_q;
    logic [3:0]        byteenable_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic              signed_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    err_e              rsp_err_q;

    logic [1:0]        req_off_d;
    logic              misalign_d;
    logic              timeout_d;
    logic [31:0]       load_d;

    assign req_off_d  = req_addr[1:0];
    assign misalign_d = is_misaligned(req_size, req_off_d);
    assign timeout_d  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

    mips_load_extract u_extract (
        .readdata_i (readdata),
        .off_i      (off_q),
        .size_i     (size_q),
        .signed_i   (signed_q),
        .rdata_o    (load_d)
    );

    // Transfer sequencer; every bus and response output comes straight from a register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            address_q    <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            size_q       <= '0;
            off_q        <= '0;
            signed_q     <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= ERR_OK;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        size_q   <= req_size;
                        off_q    <= req_off_d;
                        signed_q <= req_signed;
                        cnt_q    <= '0;
                        if (misalign_d) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= ERR_ALIGN;
                        end else begin
                            state_q      <= ST_BUS;
                            address_q    <= {req_addr[ADDR_W-1:2], 2'b00};
                            byteenable_q <= be_gen(req_size, req_off_d);
                            writedata_q  <= wdata_rep(req_size, req_wdata);
                            read_q       <= ~req_write;
                            write_q      <= req_write;
                        end
                    end
                end
                ST_BUS: begin
                    if (!waitrequest) begin
                        state_q     <= ST_RESP;
                        read_q      <= 1'b0;
                        write_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= write_q ? 32'd0 : load_d;
                        rsp_err_q   <= ERR_OK;
                    end else if (timeout_d) begin
                        state_q     <= ST_RESP;
                        read_q      <= 1'b0;
                        write_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_mips_bus_master.sv
// Self-checking bench for mips_bus_master: table of directed transfers with a
// response scoreboard, plus reset-state and mid-transfer reset checks.
module tb_mips_bus_master;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        busy;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t expQ[$];
    int   totalChecks = 0;
    int   badChecks   = 0;

    mips_bus_master #(
        .ADDR_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something upstream stops making progress
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue one request, act as a slave with the given stall count, and
    // compare the bus side each cycle and the response against the scoreboard
    task automatic applyStimulus(
        input string       name,
        input logic        wr,
        input logic [1:0]  size,
        input logic        sgn,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] busData,
        input int          stalls,
        input logic [31:0] expAddr,
        input logic [3:0]  expBe,
        input logic [31:0] expWdata,
        input logic [31:0] expRdata,
        input logic [1:0]  expErr,
        input int          expBus
    );
        exp_t expEntry;
        int   busCycles;
        int   rspCycle;
        int   waitCnt;
        $display("[TB] transfer %s", name);
        waitCnt = 0;
        @(negedge clk);
        while (!req_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput({name, "_ready"}, 32'(req_ready), 32'd1);
        expQ.push_back('{rdata: expRdata, err: expErr});
        req_write   = wr;
        req_size    = size;
        req_signed  = sgn;
        req_addr    = addr;
        req_wdata   = wdata;
        req_valid   = 1'b1;
        readdata    = busData;
        waitrequest = 1'b0;
        @(posedge clk);
        busCycles = 0;
        rspCycle  = 0;
        for (int cyc = 1; cyc <= 40 && rspCycle == 0; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (read || write) begin
                busCycles++;
                checkOutput({name, "_rdwr_excl"}, 32'(read & write), 32'd0);
                checkOutput({name, "_write"}, 32'(write), 32'(wr));
                checkOutput({name, "_address"}, address, expAddr);
                checkOutput({name, "_byteenable"}, 32'(byteenable), 32'(expBe));
                if (wr)
                    checkOutput({name, "_writedata"}, writedata, expWdata);
                waitrequest = (busCycles <= stalls);
            end
            if (rsp_valid) begin
                rspCycle = cyc;
                if (expQ.size() == 0) begin
                    checkOutput({name, "_rsp_unexpected"}, 32'd1, 32'd0);
                end else begin
                    expEntry = expQ.pop_front();
                    checkOutput({name, "_rsp_rdata"}, rsp_rdata, expEntry.rdata);
                    checkOutput({name, "_rsp_err"}, 32'(rsp_err), 32'(expEntry.err));
                end
            end
        end
        waitrequest = 1'b0;
        checkOutput({name, "_rsp_seen"}, 32'(rspCycle != 0), 32'd1);
        checkOutput({name, "_bus_cycles"}, 32'(busCycles), 32'(expBus));
        checkOutput({name, "_rsp_latency"}, 32'(rspCycle), 32'(expBus + 1));
        @(negedge clk);
        checkOutput({name, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
        checkOutput({name, "_ready_back"}, 32'(req_ready), 32'd1);
        checkOutput({name, "_busy_idle"}, 32'(busy), 32'd0);
        checkOutput({name, "_rsp_hold"}, rsp_rdata, expRdata);
        checkOutput({name, "_err_hold"}, 32'(rsp_err), 32'(expErr));
    endtask

    // Main sequence
    initial begin
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = 2'd0;
        req_signed  = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        waitrequest = 1'b0;
        readdata    = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_read", 32'(read), 32'd0);
        checkOutput("reset_write", 32'(write), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_address", address, 32'd0);
        checkOutput("reset_byteenable", 32'(byteenable), 32'd0);
        checkOutput("reset_writedata", writedata, 32'd0);
        reset_n = 1'b1;

        //            name      wr    size  sgn   addr          wdata          busData        st   expAddr       expBe    expWdata       expRdata       err   bus
        applyStimulus("lw",     1'b0, 2'd2, 1'b0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 0,   32'h0000_1004, 4'b1111, 32'h0,         32'hDEAD_BEEF, 2'd0, 1);
        applyStimulus("lb",     1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0,   32'h0000_0100, 4'b1000, 32'h0,         32'hFFFF_FF80, 2'd0, 1);
        applyStimulus("lbu",    1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0,   32'h0000_0100, 4'b1000, 32'h0,         32'h0000_0080, 2'd0, 1);
        applyStimulus("sh",     1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        3,   32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0,         2'd0, 4);
        applyStimulus("lh",     1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0,        32'h8001_0000, 1,   32'h0000_0100, 4'b1100, 32'h0,         32'hFFFF_8001, 2'd0, 2);
        applyStimulus("lhu",    1'b0, 2'd1, 1'b0, 32'h0000_0100, 32'h0,        32'h1234_F00D, 0,   32'h0000_0100, 4'b0011, 32'h0,         32'h0000_F00D, 2'd0, 1);
        applyStimulus("lbu_o1", 1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0,        32'h1122_C344, 0,   32'h0000_0100, 4'b0010, 32'h0,         32'h0000_00C3, 2'd0, 1);
        applyStimulus("sb",     1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h0000_005A, 32'h0,        0,   32'h0000_0100, 4'b0010, 32'h5A5A_5A5A, 32'h0,         2'd0, 1);
        applyStimulus("sw",     1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 32'hFFFF_FFFF, 2,  32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 32'h0,         2'd0, 3);
        applyStimulus("lw_sgn", 1'b0, 2'd2, 1'b1, 32'h0000_0008, 32'h0,        32'h8765_4321, 0,   32'h0000_0008, 4'b1111, 32'h0,         32'h8765_4321, 2'd0, 1);
        applyStimulus("lw_mis", 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0,        32'h1111_1111, 0,   32'h0,         4'b0000, 32'h0,         32'h0,         2'd1, 0);
        applyStimulus("lh_mis", 1'b0, 2'd1, 1'b1, 32'h0000_0011, 32'h0,        32'h2222_2222, 0,   32'h0,         4'b0000, 32'h0,         32'h0,         2'd1, 0);
        applyStimulus("rsvd",   1'b1, 2'd3, 1'b0, 32'h0000_0010, 32'h3333_3333, 32'h0,        0,   32'h0,         4'b0000, 32'h0,         32'h0,         2'd1, 0);
        applyStimulus("tmo",    1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0,        32'h4444_4444, 100, 32'h0000_0400, 4'b1111, 32'h0,         32'h0,         2'd2, 5);
        applyStimulus("lw_ok2", 1'b0, 2'd2, 1'b0, 32'h0000_0404, 32'h0,        32'h0BAD_CAFE, 4,   32'h0000_0404, 4'b1111, 32'h0,         32'h0BAD_CAFE, 2'd0, 5);

        // Reset in the second bus cycle of a stalled read
        $display("[TB] mid-transfer reset");
        @(negedge clk);
        req_write   = 1'b0;
        req_size    = 2'd2;
        req_signed  = 1'b0;
        req_addr    = 32'h0000_0500;
        req_valid   = 1'b1;
        waitrequest = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rst_bus1_read", 32'(read), 32'd1);
        @(negedge clk);
        checkOutput("rst_bus2_read", 32'(read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_async_read", 32'(read), 32'd0);
        checkOutput("rst_async_busy", 32'(busy), 32'd0);
        checkOutput("rst_async_ready", 32'(req_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        reset_n     = 1'b1;
        waitrequest = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_release_ready", 32'(req_ready), 32'd1);
            checkOutput("rst_release_rsp", 32'(rsp_valid), 32'd0);
            checkOutput("rst_release_read", 32'(read), 32'd0);
        end
        checkOutput("rst_queue_empty", 32'(expQ.size()), 32'd0);

        applyStimulus("post_rst", 1'b0, 2'd0, 1'b1, 32'h0000_0602, 32'h0, 32'h007F_0000, 0, 32'h0000_0600, 4'b0100, 32'h0, 32'h0000_007F, 2'd0, 1);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
